unidade_escrita_registradores: RTL and testbench
================================================

Name: unidade_escrita_registradores

Overview:
- Write-back side of the 32x32 register file: collects results from the ALU and memory-load paths and serialises them into the register file's single write port (escreve_R / endereco_E / dados).
- Buffers writes in a small in-order queue.
- Exposes per-operand pending/forwarding lookups so decode can stall or bypass while a write is still in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
PROFUNDIDADE, 4, queue depth in entries; power of two, >= 2
LARGURA_DADOS, 32, data width
LARGURA_END, 5, register address width

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
mem_valido  in  1  memory-load result offered
mem_endereco  in  5  destination register of load
mem_dados  in  32  load data
aceita_mem  out  1  queue accepts memory result this cycle
ula_valido  in  1  ALU result offered
ula_endereco  in  5  destination register of ALU result
ula_dados  in  32  ALU result
aceita_ula  out  1  queue accepts ALU result this cycle
escreve_R  out  1  register-file write enable (registered)
endereco_E  out  5  register-file write address (registered)
dados  out  32  register-file write data (registered)
consulta_rs  in  5  rs operand address to check
consulta_rt  in  5  rt operand address to check
pendente_rs  out  1  rs has an unretired write
pendente_rt  out  1  rt has an unretired write
encaminha_rs  out  32  newest pending data for rs
encaminha_rt  out  32  newest pending data for rt
vazio  out  1  queue empty and no write in the output register

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset effects:
  - Queue cleared (count 0, pointers 0).
  - escreve_R=0, endereco_E=0, dados=0.
  - vazio=1; aceita_mem=1, aceita_ula=1.
  - Reset mid-operation discards all queued writes; nothing is retired on or after the reset edge.
- Handshake: a transfer occurs when valido && aceita at the posedge. Sources hold their valid/address/data stable until accepted.
- Free space: livre = PROFUNDIDADE - count, taken from registered count only; same-cycle drain is not credited.
- Ready rules (combinational):
  - aceita_mem = livre>=1.
  - aceita_ula = livre>=2 || (livre>=1 && !mem_valido). The memory path has priority.
- Ordering when both transfer in the same cycle: the memory entry is enqueued first (older), then the ALU entry. The count increments by 2.
- Register 0: transfers addressed to register 0 complete the handshake but are not enqueued and never drive escreve_R.
- Drain, one per cycle:
  - If the queue is non-empty, the head is popped and loaded into the output register; escreve_R=1 on the following cycle with that entry's address and data.
  - If the queue is empty, escreve_R=0; endereco_E and dados hold their last values.
  - Enqueue and dequeue in the same cycle are legal; count = count + enq - deq.
- Latency: an accepted result into an empty queue appears on escreve_R two posedges after acceptance. The register file commits it at the third posedge.
- Full: when count==PROFUNDIDADE, both aceita outputs are 0. Drain continues.
- Pointers wrap modulo PROFUNDIDADE.
- Lookup (combinational, per operand):
  - Candidates are all valid queue entries plus the output register while escreve_R=1.
  - pendente = any address match.
  - encaminha = data of the newest match, in priority order: queue tail, toward the head, then the output register.
  - No match, or address 0: pendente=0 and encaminha=0.
  - Lookups ignore same-cycle incoming transfers.
- vazio = (count==0) && !escreve_R.

Decomposition:
- Shared package: LARGURA_DADOS, LARGURA_END, and the register-0 constant. The register file uses the same package.
- Sub-module fila_escrita holds the storage array, pointers and count, and exports all entries for the lookup.
- Arbitration, output register and lookup stay in the top module.

Test Plan:
- Reset, then ula_valido=1, ula_endereco=8, ula_dados=0x1234 for one cycle -> accepted at cycle 0; escreve_R=1, endereco_E=8, dados=0x1234 at cycle 2 only; vazio returns to 1 at cycle 3.
- mem(5, 0xAAAA) and ula(6, 0xBBBB) in the same cycle into an empty queue -> both accepted; writes retire in order reg5 then reg6 on consecutive cycles.
- Fill queue to 4 with drain active, then offer both sources when livre=1 -> aceita_mem=1, aceita_ula=0; the ALU result is accepted the following cycle.
- Enqueue reg9=0x1, then reg9=0x2; set consulta_rs=9 -> pendente_rs=1, encaminha_rs=0x2; after both retire -> pendente_rs=0, encaminha_rs=0.
- ula_endereco=0 with data 0xFFFF -> aceita_ula=1, count unchanged, escreve_R never asserted; consulta_rt=0 -> pendente_rt=0.
- Three entries queued, reset asserted for one cycle -> next cycle escreve_R=0, vazio=1, aceita_*=1; no queued entry is ever written.

Source files
------------

// File: rtl/unidade_escrita_registradores_pkg.sv
// Shared register-file constants, used by the write-back unit and by the register file.
package unidade_escrita_registradores_pkg;

    localparam int LARGURA_DADOS = 32;
    localparam int LARGURA_END   = 5;
    localparam logic [LARGURA_END-1:0] REG_ZERO = '0;

endpackage

// File: rtl/unidade_escrita_registradores_fila_escrita.sv
// In-order write queue with two enqueue ports (A is older than B) and one pop per cycle.
// Every slot is exported so the lookup logic can scan the pending writes.
module fila_escrita
    import unidade_escrita_registradores_pkg::*;
#(
    parameter int PROFUNDIDADE = 4,
    parameter int W_DADOS      = LARGURA_DADOS,
    parameter int W_END        = LARGURA_END,
    localparam int PW          = $clog2(PROFUNDIDADE),
    localparam int CW          = PW + 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  enq_a_i,
    input  logic [W_END-1:0]                      end_a_i,
    input  logic [W_DADOS-1:0]                    dados_a_i,
    input  logic                                  enq_b_i,
    input  logic [W_END-1:0]                      end_b_i,
    input  logic [W_DADOS-1:0]                    dados_b_i,
    input  logic                                  deq_i,
    output logic [CW-1:0]                         count_o,
    output logic [PW-1:0]                         cab_o,
    output logic [PROFUNDIDADE-1:0][W_END-1:0]    end_o,
    output logic [PROFUNDIDADE-1:0][W_DADOS-1:0]  dados_o
);

    logic [PW-1:0] cab_q, cab_d, cauda_q, cauda_d, pos_b;
    logic [CW-1:0] count_q, count_d, n_enq;
    logic [PROFUNDIDADE-1:0][W_END-1:0]   end_q;
    logic [PROFUNDIDADE-1:0][W_DADOS-1:0] dados_q;

    always_comb begin
        n_enq   = CW'(enq_a_i) + CW'(enq_b_i);
        // B lands behind A when both arrive together
        pos_b   = enq_a_i ? cauda_q + PW'(1) : cauda_q;
        cauda_d = cauda_q + n_enq[PW-1:0];
        cab_d   = cab_q + PW'(deq_i);
        count_d = count_q + n_enq - CW'(deq_i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cab_q   <= '0;
            cauda_q <= '0;
            count_q <= '0;
        end else begin
            cab_q   <= cab_d;
            cauda_q <= cauda_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_a_i) begin
            end_q[cauda_q]   <= end_a_i;
            dados_q[cauda_q] <= dados_a_i;
        end
        if (enq_b_i) begin
            end_q[pos_b]   <= end_b_i;
            dados_q[pos_b] <= dados_b_i;
        end
    end

    assign count_o = count_q;
    assign cab_o   = cab_q;
    assign end_o   = end_q;
    assign dados_o = dados_q;

endmodule

// File: rtl/unidade_escrita_registradores.sv
// Write-back unit: arbitrates ALU and load results into a write queue, drains it into the
// register file's single write port and answers pending/forwarding lookups for decode.
module unidade_escrita_registradores
    import unidade_escrita_registradores_pkg::*;
#(
    parameter int PROFUNDIDADE  = 4,
    parameter int LARGURA_DADOS = unidade_escrita_registradores_pkg::LARGURA_DADOS,
    parameter int LARGURA_END   = unidade_escrita_registradores_pkg::LARGURA_END
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_valido,
    input  logic [LARGURA_END-1:0]   mem_endereco,
    input  logic [LARGURA_DADOS-1:0] mem_dados,
    output logic                     aceita_mem,
    input  logic                     ula_valido,
    input  logic [LARGURA_END-1:0]   ula_endereco,
    input  logic [LARGURA_DADOS-1:0] ula_dados,
    output logic                     aceita_ula,
    output logic                     escreve_R,
    output logic [LARGURA_END-1:0]   endereco_E,
    output logic [LARGURA_DADOS-1:0] dados,
    input  logic [LARGURA_END-1:0]   consulta_rs,
    input  logic [LARGURA_END-1:0]   consulta_rt,
    output logic                     pendente_rs,
    output logic                     pendente_rt,
    output logic [LARGURA_DADOS-1:0] encaminha_rs,
    output logic [LARGURA_DADOS-1:0] encaminha_rt,
    output logic                     vazio
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;
    localparam logic [LARGURA_END-1:0] ZERO = LARGURA_END'(REG_ZERO);

    logic [CW-1:0] count, livre;
    logic [PW-1:0] cab;
    logic [PROFUNDIDADE-1:0][LARGURA_END-1:0]   fila_end;
    logic [PROFUNDIDADE-1:0][LARGURA_DADOS-1:0] fila_dados;
    logic enq_mem, enq_ula, deq;

    logic                     escreve_q, escreve_d;
    logic [LARGURA_END-1:0]   end_q, end_d;
    logic [LARGURA_DADOS-1:0] dados_q, dados_d;

    // Free space ignores this cycle's pop so readiness never depends on the drain path
    assign livre      = CW'(PROFUNDIDADE) - count;
    assign aceita_mem = (livre != '0);
    assign aceita_ula = (livre >= CW'(2)) || (aceita_mem && !mem_valido);
    assign enq_mem    = mem_valido && aceita_mem && (mem_endereco != ZERO);
    assign enq_ula    = ula_valido && aceita_ula && (ula_endereco != ZERO);
    assign deq        = (count != '0);

    fila_escrita #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .W_DADOS      (LARGURA_DADOS),
        .W_END        (LARGURA_END)
    ) u_fila (
        .clock     (clock),
        .reset     (reset),
        .enq_a_i   (enq_mem),
        .end_a_i   (mem_endereco),
        .dados_a_i (mem_dados),
        .enq_b_i   (enq_ula),
        .end_b_i   (ula_endereco),
        .dados_b_i (ula_dados),
        .deq_i     (deq),
        .count_o   (count),
        .cab_o     (cab),
        .end_o     (fila_end),
        .dados_o   (fila_dados)
    );

    always_comb begin
        escreve_d = deq;
        end_d     = end_q;
        dados_d   = dados_q;
        if (deq) begin
            end_d   = fila_end[cab];
            dados_d = fila_dados[cab];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            escreve_q <= 1'b0;
            end_q     <= '0;
            dados_q   <= '0;
        end else begin
            escreve_q <= escreve_d;
            end_q     <= end_d;
            dados_q   <= dados_d;
        end
    end

    logic [1:0][LARGURA_END-1:0]   alvo;
    logic [1:0]                    pend;
    logic [1:0][LARGURA_DADOS-1:0] enc;

    assign alvo = {consulta_rt, consulta_rs};

    // Scan oldest to newest so the last hit (closest to the tail) wins
    always_comb begin
        pend = '0;
        enc  = '0;
        for (int op = 0; op < 2; op++) begin
            if (escreve_q && end_q == alvo[op]) begin
                pend[op] = 1'b1;
                enc[op]  = dados_q;
            end
            for (int k = 0; k < PROFUNDIDADE; k++) begin
                if (CW'(k) < count && fila_end[cab + PW'(k)] == alvo[op]) begin
                    pend[op] = 1'b1;
                    enc[op]  = fila_dados[cab + PW'(k)];
                end
            end
            if (alvo[op] == ZERO) begin
                pend[op] = 1'b0;
                enc[op]  = '0;
            end
        end
    end

    assign pendente_rs  = pend[0];
    assign pendente_rt  = pend[1];
    assign encaminha_rs = enc[0];
    assign encaminha_rt = enc[1];
    assign escreve_R    = escreve_q;
    assign endereco_E   = end_q;
    assign dados        = dados_q;
    assign vazio        = (count == '0) && !escreve_q;

endmodule

// File: tb/tb_unidade_escrita_registradores.sv
// Bench for the write-back unit: directed scenarios plus randomized traffic against a queue model.
module tb_unidade_escrita_registradores;

    localparam int PROF = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valido = 1'b0, ula_valido = 1'b0;
    logic [4:0]  mem_endereco = '0, ula_endereco = '0, consulta_rs = '0, consulta_rt = '0;
    logic [31:0] mem_dados = '0, ula_dados = '0;
    logic        aceita_mem, aceita_ula, escreve_R, pendente_rs, pendente_rt, vazio;
    logic [4:0]  endereco_E;
    logic [31:0] dados, encaminha_rs, encaminha_rt;

    int n_testes = 0;
    int n_falhas = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        mo_v = 1'b0;
    logic [4:0]  mo_a = '0;
    logic [31:0] mo_d = '0;
    logic        acc_m, acc_u;

    unidade_escrita_registradores dut (
        .clock        (clock),
        .reset        (reset),
        .mem_valido   (mem_valido),
        .mem_endereco (mem_endereco),
        .mem_dados    (mem_dados),
        .aceita_mem   (aceita_mem),
        .ula_valido   (ula_valido),
        .ula_endereco (ula_endereco),
        .ula_dados    (ula_dados),
        .aceita_ula   (aceita_ula),
        .escreve_R    (escreve_R),
        .endereco_E   (endereco_E),
        .dados        (dados),
        .consulta_rs  (consulta_rs),
        .consulta_rt  (consulta_rt),
        .pendente_rs  (pendente_rs),
        .pendente_rt  (pendente_rt),
        .encaminha_rs (encaminha_rs),
        .encaminha_rt (encaminha_rt),
        .vazio        (vazio)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_testes++;
        assert (obs === exp) else begin
            n_falhas++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Newest pending write to a register: queue tail first, then the retiring write
    function automatic logic [32:0] busca(input logic [4:0] alvo);
        if (alvo == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == alvo) return {1'b1, mq[i].d};
        if (mo_v && mo_a == alvo) return {1'b1, mo_d};
        return '0;
    endfunction

    task automatic aplica(input logic rst, input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic uv, input logic [4:0] ua, input logic [31:0] ud,
                          input logic [4:0] rs, input logic [4:0] rt);
        int livre;
        logic [32:0] r, t;
        #1;
        reset = rst; mem_valido = mv; mem_endereco = ma; mem_dados = md;
        ula_valido = uv; ula_endereco = ua; ula_dados = ud;
        consulta_rs = rs; consulta_rt = rt;
        livre = PROF - mq.size();
        acc_m = (livre >= 1);
        acc_u = (livre >= 2) || (livre >= 1 && !mv);
        @(negedge clock); #1;
        r = busca(rs);
        t = busca(rt);
        chk("aceita_mem", 32'(aceita_mem), 32'(acc_m));
        chk("aceita_ula", 32'(aceita_ula), 32'(acc_u));
        chk("escreve_R", 32'(escreve_R), 32'(mo_v));
        chk("endereco_E", 32'(endereco_E), 32'(mo_a));
        chk("dados", dados, mo_d);
        chk("pendente_rs", 32'(pendente_rs), 32'(r[32]));
        chk("encaminha_rs", encaminha_rs, r[31:0]);
        chk("pendente_rt", 32'(pendente_rt), 32'(t[32]));
        chk("encaminha_rt", encaminha_rt, t[31:0]);
        chk("vazio", 32'(vazio), 32'(mq.size() == 0 && !mo_v));
    endtask

    task automatic avanca();
        ent_t e;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            mo_v = 1'b0; mo_a = '0; mo_d = '0;
        end else begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                mo_v = 1'b1; mo_a = e.a; mo_d = e.d;
            end else begin
                mo_v = 1'b0;
            end
            if (mem_valido && acc_m && mem_endereco != 5'd0) mq.push_back({mem_endereco, mem_dados});
            if (ula_valido && acc_u && ula_endereco != 5'd0) mq.push_back({ula_endereco, ula_dados});
        end
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) begin
            aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
            avanca();
        end
    endtask

    initial begin
        logic rmv, ruv, rrst;
        logic [4:0] rma, rua, rrs, rrt;
        logic [31:0] rmd, rud;

        aplica(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0); avanca();
        aplica(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0); avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("rst_vazio", 32'(vazio), 32'd1);
        chk("rst_escreve", 32'(escreve_R), 32'd0);
        chk("rst_aceita", {30'd0, aceita_mem, aceita_ula}, 32'd3);
        avanca();

        // Single ALU write: visible on the write port two cycles after acceptance
        aplica(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, 32'h1234, '0, '0);
        chk("s1_aceita", 32'(aceita_ula), 32'd1);
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("s1_c1_escreve", 32'(escreve_R), 32'd0);
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("s1_c2_escreve", 32'(escreve_R), 32'd1);
        chk("s1_c2_end", 32'(endereco_E), 32'd8);
        chk("s1_c2_dados", dados, 32'h1234);
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("s1_c3_escreve", 32'(escreve_R), 32'd0);
        chk("s1_c3_vazio", 32'(vazio), 32'd1);
        avanca();

        // Simultaneous load and ALU result: load retires first
        aplica(1'b0, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, '0, '0);
        chk("s2_aceita", {30'd0, aceita_mem, aceita_ula}, 32'd3);
        avanca();
        ocioso(1);
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("s2_primeiro", {dados[15:0], 11'd0, endereco_E}, {16'hAAAA, 11'd0, 5'd5});
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        chk("s2_segundo", {dados[15:0], 11'd0, endereco_E}, {16'hBBBB, 11'd0, 5'd6});
        avanca();
        ocioso(1);

        // Nearly full: memory path wins the last free slot
        aplica(1'b0, 1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, '0, '0); avanca();
        aplica(1'b0, 1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h40, '0, '0); avanca();
        aplica(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd12, 32'hC0, '0, '0);
        chk("s3_mem_prio", {30'd0, aceita_mem, aceita_ula}, 32'd2);
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'hC0, '0, '0);
        chk("s3_ula_depois", 32'(aceita_ula), 32'd1);
        avanca();
        ocioso(5);

        // Forwarding returns the newest of two writes to the same register
        aplica(1'b0, 1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, '0); avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0);
        chk("s4_pend", 32'(pendente_rs), 32'd1);
        chk("s4_enc", encaminha_rs, 32'h2);
        avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0); avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0); avanca();
        aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0);
        chk("s4_pend_fim", 32'(pendente_rs), 32'd0);
        chk("s4_enc_fim", encaminha_rs, 32'd0);
        avanca();

        // Register 0 is accepted but never written
        aplica(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, '0, 5'd0);
        chk("s5_aceita", 32'(aceita_ula), 32'd1);
        avanca();
        for (int i = 0; i < 3; i++) begin
            aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 5'd0);
            chk("s5_escreve", 32'(escreve_R), 32'd0);
            chk("s5_vazio", 32'(vazio), 32'd1);
            chk("s5_pend_rt", 32'(pendente_rt), 32'd0);
            avanca();
        end

        // Reset discards queued writes
        aplica(1'b0, 1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE, '0, '0); avanca();
        aplica(1'b0, 1'b1, 5'd15, 32'hF, 1'b1, 5'd16, 32'h10, '0, '0); avanca();
        aplica(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0); avanca();
        for (int i = 0; i < 4; i++) begin
            aplica(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd15, 5'd16);
            chk("s6_escreve", 32'(escreve_R), 32'd0);
            chk("s6_vazio", 32'(vazio), 32'd1);
            chk("s6_aceita", {30'd0, aceita_mem, aceita_ula}, 32'd3);
            avanca();
        end

        // Random traffic; offers are held until accepted
        rmv = 1'b0; ruv = 1'b0; rma = '0; rua = '0; rmd = '0; rud = '0;
        for (int i = 0; i < 400; i++) begin
            if (!rmv && $urandom_range(0, 1) == 1) begin
                rmv = 1'b1; rma = 5'($urandom_range(0, 7)); rmd = $urandom;
            end
            if (!ruv && $urandom_range(0, 2) != 0) begin
                ruv = 1'b1; rua = 5'($urandom_range(0, 7)); rud = $urandom;
            end
            rrs  = 5'($urandom_range(0, 7));
            rrt  = 5'($urandom_range(0, 7));
            rrst = ($urandom_range(0, 99) == 0);
            aplica(rrst, rmv, rma, rmd, ruv, rua, rud, rrs, rrt);
            avanca();
            if (rmv && acc_m) rmv = 1'b0;
            if (ruv && acc_u) ruv = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
